fec_parity_insert: RTL and testbench

FEC_PARITY_INSERT -- requirements
Module: fec_parity_insert

---
 rtl/fec_parity_insert.sv | 155 +++++++++++++++
 tb/tb_fec_parity_insert.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fec_parity_insert.sv
// FEC parity inserter: forwards 65-bit transcoded blocks and appends a 32-bit parity word after each frame.
// Optional PN-2112 output scrambler is compiled in when FEC_ENC_SCRAMBLE_EN is defined.
module fec_parity_insert #(
    parameter int          BLKS_PER_FRM = 32,
    parameter logic [31:0] PAR_POLY     = 32'h00A00805
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENC_EN,
    input  logic        T_BLK_ENA,
    input  logic [64:0] T_BLK,
    output logic        E_BLK_ENA,
    output logic [64:0] E_BLK,
    output logic        E_PAR_VAL,
    output logic        E_FRM_START,
    output logic        ERR_SLOT,
    output logic [15:0] ERR_CNT
);

    localparam int CNT_W = (BLKS_PER_FRM > 1) ? $clog2(BLKS_PER_FRM) : 1;
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLKS_PER_FRM - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_blk_cnt;
    logic [31:0]      r_par;

    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_emit_par;
    logic             w_drop;
    logic             w_blk0;
    logic [64:0]      w_scr_mask;

    // Division register: the first line bit ends up as the highest-degree message term.
    function automatic logic [31:0] par_step(input logic [31:0] rem, input logic [64:0] blk);
        logic [31:0] r;
        r = rem;
        for (int i = 0; i < 65; i++) begin
            if (r[31])
                r = {r[30:0], blk[i]} ^ PAR_POLY;
            else
                r = {r[30:0], blk[i]};
        end
        return r;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_emit_par  = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE, S_DATA: begin
                if (T_BLK_ENA) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_blk_cnt == LAST_BLK) ? S_PAR : S_DATA;
                end
            end
            S_PAR: begin
                // A block arriving in the parity slot is lost; the frame restarts after it.
                w_emit_par  = 1'b1;
                w_drop      = T_BLK_ENA;
                w_state_nxt = S_DATA;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!ENC_EN) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_emit_par  = 1'b0;
            w_drop      = 1'b0;
        end
    end

    assign w_blk0 = w_accept && (r_blk_cnt == '0);

`ifdef FEC_ENC_SCRAMBLE_EN
    logic [57:0] r_scr;
    logic [57:0] w_scr_base;

    function automatic logic [64:0] scr_bits(input logic [57:0] s_in);
        logic [57:0] s;
        logic [64:0] m;
        s = s_in;
        for (int i = 0; i < 65; i++) begin
            m[i] = s[57] ^ s[38];
            s    = {s[56:0], m[i]};
        end
        return m;
    endfunction

    function automatic logic [57:0] scr_next(input logic [57:0] s_in);
        logic [57:0] s;
        s = s_in;
        for (int i = 0; i < 65; i++)
            s = {s[56:0], s[57] ^ s[38]};
        return s;
    endfunction

    assign w_scr_base = w_blk0 ? '1 : r_scr;
    assign w_scr_mask = scr_bits(w_scr_base);

    always_ff @(posedge CLK) begin
        if (RST)
            r_scr <= '1;
        else if (w_accept || w_emit_par)
            r_scr <= scr_next(w_scr_base);
    end
`else
    assign w_scr_mask = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_blk_cnt   <= '0;
            r_par       <= '0;
            E_BLK_ENA   <= 1'b0;
            E_BLK       <= '0;
            E_PAR_VAL   <= 1'b0;
            E_FRM_START <= 1'b0;
            ERR_SLOT    <= 1'b0;
            ERR_CNT     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            E_BLK_ENA   <= w_accept || w_emit_par;
            E_PAR_VAL   <= w_emit_par;
            E_FRM_START <= w_blk0;
            ERR_SLOT    <= w_drop;
            if (w_drop && (ERR_CNT != 16'hFFFF))
                ERR_CNT <= ERR_CNT + 16'd1;

            if (w_accept)
                E_BLK <= T_BLK ^ w_scr_mask;
            else if (w_emit_par)
                E_BLK <= {33'b0, r_par} ^ w_scr_mask;
            else
                E_BLK <= '0;

            // The remainder is held through the parity slot and cleared as it is emitted.
            if (w_accept) begin
                r_par     <= par_step(r_par, T_BLK);
                r_blk_cnt <= (r_blk_cnt == LAST_BLK) ? '0 : r_blk_cnt + CNT_W'(1);
            end else if (w_emit_par || (w_state_nxt == S_IDLE)) begin
                r_par     <= '0;
                r_blk_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fec_parity_insert.sv
// Self-checking bench for fec_parity_insert: directed frames plus randomized traffic against a frame-level model.
module tb_fec_parity_insert;

    localparam int          N    = 32;
    localparam logic [31:0] POLY = 32'h00A00805;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENC_EN;
    logic        T_BLK_ENA;
    logic [64:0] T_BLK;
    logic        E_BLK_ENA;
    logic [64:0] E_BLK;
    logic        E_PAR_VAL;
    logic        E_FRM_START;
    logic        ERR_SLOT;
    logic [15:0] ERR_CNT;

    fec_parity_insert #(.BLKS_PER_FRM(N), .PAR_POLY(POLY)) dut (
        .CLK(CLK), .RST(RST), .ENC_EN(ENC_EN), .T_BLK_ENA(T_BLK_ENA), .T_BLK(T_BLK),
        .E_BLK_ENA(E_BLK_ENA), .E_BLK(E_BLK), .E_PAR_VAL(E_PAR_VAL),
        .E_FRM_START(E_FRM_START), .ERR_SLOT(ERR_SLOT), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // x^k mod g(x), so a frame's remainder is the XOR of the terms for its set bits.
    logic [31:0] xpow [N*65];
    logic [64:0] m_frm [$];
    bit          m_slot;
    logic        x_ena, x_par, x_fs, x_err;
    logic [64:0] x_blk, x_mask;
    logic [15:0] x_cnt;
    bit          pn_q [$];
    logic [64:0] last_par;
    logic [64:0] ref_par;

    function automatic logic [31:0] frame_rem();
        logic [31:0] r;
        int          nb;
        r  = '0;
        nb = m_frm.size() * 65;
        for (int j = 0; j < m_frm.size(); j++)
            for (int i = 0; i < 65; i++)
                if (m_frm[j][i]) r ^= xpow[nb - 1 - (j*65 + i)];
        return r;
    endfunction

    task automatic pn_seed();
        pn_q.delete();
        for (int i = 0; i < 58; i++) pn_q.push_back(1'b1);
    endtask

    // Additive PN sequence b[n] = b[n-58] ^ b[n-39]; zero when the scrambler is not built.
    task automatic pn_next(output logic [64:0] m);
        m = '0;
`ifdef FEC_ENC_SCRAMBLE_EN
        for (int i = 0; i < 65; i++) begin
            m[i] = pn_q[pn_q.size()-58] ^ pn_q[pn_q.size()-39];
            pn_q.push_back(m[i]);
            void'(pn_q.pop_front());
        end
`endif
    endtask

    task automatic model(input bit rst, input bit en, input bit vld, input logic [64:0] blk);
        x_ena = 0; x_blk = '0; x_par = 0; x_fs = 0; x_err = 0; x_mask = '0;
        if (rst) begin
            m_frm.delete(); m_slot = 0; x_cnt = '0; pn_seed();
        end else if (!en) begin
            m_frm.delete(); m_slot = 0;
        end else if (m_slot) begin
            x_ena = 1; x_par = 1;
            pn_next(x_mask);
            x_blk = {33'b0, frame_rem()};
            if (vld) begin
                x_err = 1;
                if (x_cnt != 16'hFFFF) x_cnt = x_cnt + 16'd1;
            end
            m_frm.delete(); m_slot = 0;
        end else if (vld) begin
            if (m_frm.size() == 0) begin
                x_fs = 1; pn_seed();
            end
            x_ena = 1;
            pn_next(x_mask);
            x_blk = blk;
            m_frm.push_back(blk);
            if (m_frm.size() == N) m_slot = 1;
        end
        x_blk ^= x_mask;
    endtask

    task automatic step(input bit rst, input bit en, input bit vld, input logic [64:0] blk);
        RST = rst; ENC_EN = en; T_BLK_ENA = vld; T_BLK = blk;
        model(rst, en, vld, blk);
        @(posedge CLK);
        #1;
        check_val("e_blk_ena",   65'(E_BLK_ENA),   65'(x_ena));
        check_val("e_blk",       E_BLK,            x_blk);
        check_val("e_par_val",   65'(E_PAR_VAL),   65'(x_par));
        check_val("e_frm_start", 65'(E_FRM_START), 65'(x_fs));
        check_val("err_slot",    65'(ERR_SLOT),    65'(x_err));
        check_val("err_cnt",     65'(ERR_CNT),     65'(x_cnt));
        if (E_PAR_VAL) last_par = E_BLK ^ x_mask;
    endtask

    function automatic logic [64:0] rnd_blk();
        return {1'($urandom), $urandom(), $urandom()};
    endfunction

    // kind: 0 all zero, 1 impulse in block 0, 2 random.
    task automatic send_frame(input int kind, input int stall_at, input bit slot_hit);
        logic [64:0] b;
        for (int k = 0; k < N; k++) begin
            b = (kind == 2) ? rnd_blk() : ((kind == 1 && k == 0) ? 65'h1 : 65'h0);
            step(0, 1, 1, b);
            if (k == stall_at) repeat (3) step(0, 1, 0, '0);
        end
        step(0, 1, slot_hit, slot_hit ? rnd_blk() : 65'h0);
        step(0, 1, 0, '0);
    endtask

    initial begin
        xpow[0] = 32'h1;
        for (int k = 1; k < N*65; k++)
            xpow[k] = {xpow[k-1][30:0], 1'b0} ^ (xpow[k-1][31] ? POLY : 32'h0);
        x_cnt    = '0;
        last_par = '1;
        pn_seed();

        repeat (3) step(1, 0, 0, '0);
        step(0, 0, 1, rnd_blk());

        send_frame(0, -1, 0);
        check_val("zero_frame_parity", last_par, 65'h0);

        send_frame(1, -1, 0);
        check_val("impulse_parity", last_par, {33'b0, xpow[N*65-1]});
        ref_par  = last_par;
        last_par = '1;

        send_frame(1, 10, 0);
        check_val("stall_parity", last_par, ref_par);

        send_frame(2, -1, 1);
        check_val("slot_err_cnt", 65'(ERR_CNT), 65'd1);
        send_frame(2, 5, 0);

        for (int k = 0; k < 20; k++) step(0, 1, 1, rnd_blk());
        step(0, 0, 1, rnd_blk());
        check_val("disable_outputs", {E_BLK_ENA, E_PAR_VAL, E_FRM_START, ERR_SLOT}, '0);
        repeat (3) step(0, 0, $urandom_range(0, 1), rnd_blk());
        for (int k = 0; k < 5; k++) step(0, 1, 1, rnd_blk());
        step(1, 1, 1, rnd_blk());
        check_val("reset_outputs", {E_BLK_ENA, E_BLK, E_PAR_VAL, E_FRM_START}, '0);
        step(0, 1, 0, '0);
        send_frame(2, -1, 0);

        for (int c = 0; c < 3000; c++)
            step(($urandom % 400) == 0, ($urandom % 300) != 0,
                 ($urandom % 10) != 0, rnd_blk());

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
